// File: rtl/vga_timing_gen_if.sv
// Bundle between the raster generator, its pixel source and the video pins.
// The generator side uses the master modport.
interface vga_timing_gen_if #(
  parameter int R_W = 5,
  parameter int G_W = 6,
  parameter int B_W = 5,
  parameter int X_W = 10,
  parameter int F_W = 8
);
  logic                   run;
  logic [R_W+G_W+B_W-1:0] color;
  logic [X_W-1:0]         x;
  logic [X_W-1:0]         y;
  logic                   req;
  logic                   hsync;
  logic                   vsync;
  logic                   de;
  logic [R_W-1:0]         red;
  logic [G_W-1:0]         green;
  logic [B_W-1:0]         blue;
  logic                   frame_start;
  logic                   line_start;
  logic [F_W-1:0]         frame_cnt;
  logic                   active;

  modport master (
    input  run, color,
    output x, y, req, hsync, vsync, de, red, green, blue,
           frame_start, line_start, frame_cnt, active
  );

  modport slave (
    output run, color,
    input  x, y, req, hsync, vsync, de, red, green, blue,
           frame_start, line_start, frame_cnt, active
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: issues x/y pixel requests, absorbs the
// pixel-source latency (PIPE_LAT, 1..8) and drives registered, aligned sync/de/RGB.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_PULSE  = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_PULSE  = 2,
  parameter int V_BACK   = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIPE_LAT = 2,
  parameter int R_W      = 5,
  parameter int G_W      = 6,
  parameter int B_W      = 5,
  parameter int X_W      = 10,
  parameter int F_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);

  localparam logic [HC_W-1:0] H_VIS_END = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] HS_FIRST  = HC_W'(H_ACTIVE + H_FRONT);
  localparam logic [HC_W-1:0] HS_LAST   = HC_W'(H_ACTIVE + H_FRONT + H_PULSE - 1);
  localparam logic [HC_W-1:0] H_LAST    = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0] V_VIS_END = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] VS_FIRST  = VC_W'(V_ACTIVE + V_FRONT);
  localparam logic [VC_W-1:0] VS_LAST   = VC_W'(V_ACTIVE + V_FRONT + V_PULSE - 1);
  localparam logic [VC_W-1:0] V_LAST    = VC_W'(V_TOTAL - 1);
  localparam logic            HS_ON     = 1'(HS_POL);
  localparam logic            VS_ON     = 1'(VS_POL);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  // Sync bits are carried active-high; polarity is applied only at the pins.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
    logic ls;
  } tap_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [HC_W-1:0] r_h;
  logic [VC_W-1:0] r_v;
  logic [F_W-1:0]  r_frame_cnt;
  tap_t            r_dly [PIPE_LAT];
  tap_t            w_raw;
  tap_t            w_tap;
  logic            w_active;
  logic            w_h_last;
  logic            w_v_last;
  logic            w_eof;
  logic            w_h_vis;
  logic            w_v_vis;
  logic            r_hsync;
  logic            r_vsync;
  logic            r_de;
  logic            r_fs;
  logic            r_ls;
  logic [R_W-1:0]  r_red;
  logic [G_W-1:0]  r_green;
  logic [B_W-1:0]  r_blue;

  assign w_active = (r_state != S_IDLE);
  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);
  assign w_eof    = w_h_last && w_v_last;
  assign w_h_vis  = (r_h < H_VIS_END);
  assign w_v_vis  = (r_v < V_VIS_END);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  // Dropping run on the very last position stops cleanly instead of
  // scanning a whole extra frame in DRAIN.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.run) w_state_nxt = S_RUN;
      S_RUN:   if (!bus.run) w_state_nxt = w_eof ? S_IDLE : S_DRAIN;
      S_DRAIN: begin
        if (bus.run)    w_state_nxt = S_RUN;
        else if (w_eof) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h         <= '0;
      r_v         <= '0;
      r_frame_cnt <= '0;
    end else if (w_active) begin
      if (w_h_last) begin
        r_h <= '0;
        if (w_v_last) begin
          r_v         <= '0;
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end else begin
          r_v <= r_v + 1'b1;
        end
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  always_comb begin
    w_raw    = '0;
    w_raw.de = w_active && w_h_vis && w_v_vis;
    w_raw.hs = w_active && (r_h >= HS_FIRST) && (r_h <= HS_LAST);
    w_raw.vs = w_active && (r_v >= VS_FIRST) && (r_v <= VS_LAST);
    w_raw.fs = w_active && (r_h == '0) && (r_v == '0);
    w_raw.ls = w_active && (r_h == '0) && w_v_vis;
  end

  // NOTE: the delay line is a handful of flops, not a RAM, so it is reset; a
  // stale de/sync bit would otherwise leak to the pins right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) r_dly[i] <= '0;
    end else begin
      r_dly[0] <= w_raw;
      for (int i = 1; i < PIPE_LAT; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  assign w_tap = r_dly[PIPE_LAT-1];

  // The tap lines up with the colour returned for the same request, so both
  // land in the output register together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync <= ~HS_ON;
      r_vsync <= ~VS_ON;
      r_de    <= 1'b0;
      r_fs    <= 1'b0;
      r_ls    <= 1'b0;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else begin
      r_hsync <= w_tap.hs ? HS_ON : ~HS_ON;
      r_vsync <= w_tap.vs ? VS_ON : ~VS_ON;
      r_de    <= w_tap.de;
      r_fs    <= w_tap.fs;
      r_ls    <= w_tap.ls;
      if (w_tap.de) {r_red, r_green, r_blue} <= bus.color;
      else          {r_red, r_green, r_blue} <= '0;
    end
  end

  assign bus.req         = w_raw.de;
  assign bus.x           = w_raw.de ? X_W'(r_h) : '0;
  assign bus.y           = w_raw.de ? X_W'(r_v) : '0;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.de          = r_de;
  assign bus.red         = r_red;
  assign bus.green       = r_green;
  assign bus.blue        = r_blue;
  assign bus.frame_start = r_fs;
  assign bus.line_start  = r_ls;
  assign bus.frame_cnt   = r_frame_cnt;
  assign bus.active      = w_active;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances of a small mode (active-low, F_W=2 and
// active-high, F_W=8) checked every cycle against a raster model via a queue.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HP = 3, HB = 2;
  localparam int VA = 4, VF = 1, VP = 2, VB = 1;
  localparam int HT = HA + HF + HP + HB;  // 15
  localparam int VT = VA + VF + VP + VB;  // 8
  localparam int FT = HT * VT;            // 120
  localparam int LAT = 2;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic        ls;
    logic [15:0] rgb;
  } dly_t;

  typedef struct packed {
    logic       req;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic [7:0] fcnt;
    dly_t       v;
  } snap_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic run   = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  dly_t sb_q[$];

  always #5 clk = ~clk;

  vga_timing_gen_if #(.R_W(5), .G_W(6), .B_W(5), .X_W(10), .F_W(2)) if_a ();
  vga_timing_gen_if #(.R_W(5), .G_W(6), .B_W(5), .X_W(10), .F_W(8)) if_b ();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB),
    .HS_POL(0), .VS_POL(0), .PIPE_LAT(LAT),
    .R_W(5), .G_W(6), .B_W(5), .X_W(10), .F_W(2)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB),
    .HS_POL(1), .VS_POL(1), .PIPE_LAT(LAT),
    .R_W(5), .G_W(6), .B_W(5), .X_W(10), .F_W(8)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  function automatic logic [15:0] pix(input int px, input int py);
    return {5'(px), 6'(py), 5'(px * 3 + py)};
  endfunction

  // Pixel source: colour for a request appears LAT cycles later.
  logic [9:0] xa1, ya1, xa2, ya2, xb1, yb1, xb2, yb2;
  always @(posedge clk) begin
    xa1 <= if_a.x; ya1 <= if_a.y; xa2 <= xa1; ya2 <= ya1;
    xb1 <= if_b.x; yb1 <= if_b.y; xb2 <= xb1; yb2 <= yb1;
  end
  assign if_a.run   = run;
  assign if_b.run   = run;
  assign if_a.color = pix(int'(xa2), int'(ya2));
  assign if_b.color = pix(int'(xb2), int'(yb2));

  // Raster model: linear position within the frame, plus scanning flag.
  bit m_on;
  int m_p;
  int m_frames;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_on <= 1'b0; m_p <= 0; m_frames <= 0;
    end else if (m_on) begin
      if (m_p == FT - 1) begin
        m_p <= 0; m_frames <= m_frames + 1; m_on <= run;
      end else begin
        m_p <= m_p + 1;
      end
    end else if (run) begin
      m_on <= 1'b1;
    end
  end

  function automatic snap_t obs_a();
    snap_t s;
    s.req = if_a.req; s.x = if_a.x; s.y = if_a.y; s.active = if_a.active;
    s.fcnt = 8'(if_a.frame_cnt);
    s.v.hs = ~if_a.hsync; s.v.vs = ~if_a.vsync; s.v.de = if_a.de;
    s.v.fs = if_a.frame_start; s.v.ls = if_a.line_start;
    s.v.rgb = {if_a.red, if_a.green, if_a.blue};
    return s;
  endfunction

  function automatic snap_t obs_b();
    snap_t s;
    s.req = if_b.req; s.x = if_b.x; s.y = if_b.y; s.active = if_b.active;
    s.fcnt = if_b.frame_cnt;
    s.v.hs = if_b.hsync; s.v.vs = if_b.vsync; s.v.de = if_b.de;
    s.v.fs = if_b.frame_start; s.v.ls = if_b.line_start;
    s.v.rgb = {if_b.red, if_b.green, if_b.blue};
    return s;
  endfunction

  task automatic sb_flush();
    sb_q.delete();
    repeat (LAT + 1) sb_q.push_back('0);
  endtask

  // One cycle: push the model's expectation for the current position, pop the
  // one whose outputs are due now, and sample both DUTs.
  task automatic tick(output snap_t ea, output snap_t eb, output snap_t oa, output snap_t ob);
    dly_t d;
    int   h, v;
    @(negedge clk);
    h = m_p % HT;
    v = m_p / HT;
    d.de  = m_on && (h < HA) && (v < VA);
    d.hs  = m_on && (h >= HA + HF) && (h < HA + HF + HP);
    d.vs  = m_on && (v >= VA + VF) && (v < VA + VF + VP);
    d.fs  = m_on && (h == 0) && (v == 0);
    d.ls  = m_on && (h == 0) && (v < VA);
    d.rgb = d.de ? pix(h, v) : 16'h0;
    sb_q.push_back(d);
    ea.v      = sb_q.pop_front();
    ea.req    = d.de;
    ea.x      = d.de ? 10'(h) : 10'h0;
    ea.y      = d.de ? 10'(v) : 10'h0;
    ea.active = m_on;
    ea.fcnt   = 8'(m_frames % 4);
    eb        = ea;
    eb.fcnt   = 8'(m_frames % 256);
    oa        = obs_a();
    ob        = obs_b();
  endtask

  task automatic test_reset();
    snap_t ea, eb, oa, ob;
    run = 1'b0;
    #2 rst_n = 1'b0;
    sb_flush();
    #1;
    n_checks += 2;
    if (obs_a() !== '0) begin n_errors++; $display("FAIL reset_a got=%h exp=0", obs_a()); end
    if (obs_b() !== '0) begin n_errors++; $display("FAIL reset_b got=%h exp=0", obs_b()); end
    @(negedge clk) rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick(ea, eb, oa, ob);
      n_checks += 2;
      if (oa !== ea) begin n_errors++; $display("FAIL idle_a t=%0t got=%h exp=%h", $time, oa, ea); end
      if (ob !== eb) begin n_errors++; $display("FAIL idle_b t=%0t got=%h exp=%h", $time, ob, eb); end
    end
  endtask

  task automatic test_raster();
    snap_t ea, eb, oa, ob;
    int hs_len = 0, hs_rise = -1, de_cnt = 0, ta = -1;
    bit in_frame = 1'b0, prev_hs = 1'b0;
    run = 1'b1;
    for (int n = 0; n < 2 * FT + 20; n++) begin
      tick(ea, eb, oa, ob);
      n_checks += 2;
      if (oa !== ea) begin n_errors++; $display("FAIL raster_a t=%0t got=%h exp=%h", $time, oa, ea); end
      if (ob !== eb) begin n_errors++; $display("FAIL raster_b t=%0t got=%h exp=%h", $time, ob, eb); end
      if (oa.active && ta < 0) ta = n;
      if (oa.v.hs) begin
        if (!prev_hs) begin
          if (hs_rise >= 0) begin
            n_checks++;
            if (n - hs_rise !== HT) begin n_errors++; $display("FAIL hsync_period got=%0d exp=%0d", n - hs_rise, HT); end
          end
          hs_rise = n;
        end
        hs_len++;
      end else if (prev_hs) begin
        n_checks++;
        if (hs_len !== HP) begin n_errors++; $display("FAIL hsync_width got=%0d exp=%0d", hs_len, HP); end
        hs_len = 0;
      end
      prev_hs = oa.v.hs;
      if (oa.v.fs) begin
        n_checks++;
        if (in_frame) begin
          if (de_cnt !== HA * VA) begin n_errors++; $display("FAIL de_per_frame got=%0d exp=%0d", de_cnt, HA * VA); end
        end else if (n - ta !== LAT + 1) begin
          n_errors++; $display("FAIL first_frame_start got=%0d exp=%0d", n - ta, LAT + 1);
        end
        in_frame = 1'b1;
        de_cnt = 0;
      end
      if (oa.v.de) de_cnt++;
    end
  endtask

  task automatic test_polarity();
    snap_t ea, eb, oa, ob;
    int bh = 0, bv = 0, al = 0, cpl = 0;
    for (int n = 0; n < FT; n++) begin
      tick(ea, eb, oa, ob);
      n_checks += 2;
      if (oa !== ea) begin n_errors++; $display("FAIL pol_a t=%0t got=%h exp=%h", $time, oa, ea); end
      if (ob !== eb) begin n_errors++; $display("FAIL pol_b t=%0t got=%h exp=%h", $time, ob, eb); end
      if (if_b.hsync) bh++;
      if (if_b.vsync) bv++;
      if (!if_a.hsync) al++;
      if ((if_a.hsync === if_b.hsync) || (if_a.vsync === if_b.vsync)) cpl++;
    end
    n_checks += 4;
    if (bh !== VT * HP) begin n_errors++; $display("FAIL hs_high_cnt got=%0d exp=%0d", bh, VT * HP); end
    if (bv !== VP * HT) begin n_errors++; $display("FAIL vs_high_cnt got=%0d exp=%0d", bv, VP * HT); end
    if (al !== VT * HP) begin n_errors++; $display("FAIL hs_low_cnt got=%0d exp=%0d", al, VT * HP); end
    if (cpl !== 0) begin n_errors++; $display("FAIL pol_complement got=%0d exp=0", cpl); end
  endtask

  task automatic test_drain();
    snap_t ea, eb, oa, ob;
    int p0, f0, fall = -1, gaps = 0;
    bit found;
    for (int pass = 0; pass < 2; pass++) begin
      found = 1'b0;
      for (int n = 0; n < 2 * FT && !found; n++) begin
        tick(ea, eb, oa, ob);
        n_checks += 2;
        if (oa !== ea) begin n_errors++; $display("FAIL drain_wait_a t=%0t got=%h exp=%h", $time, oa, ea); end
        if (ob !== eb) begin n_errors++; $display("FAIL drain_wait_b t=%0t got=%h exp=%h", $time, ob, eb); end
        if (m_on && m_p == 2 * HT) found = 1'b1;
      end
      n_checks++;
      if (!found) begin n_errors++; $display("FAIL drain_timeout got=0 exp=1"); end
      p0 = m_p;
      f0 = m_frames;
      run = 1'b0;
      if (pass == 0) begin
        for (int n = 1; n <= 2 * FT; n++) begin
          tick(ea, eb, oa, ob);
          n_checks += 2;
          if (oa !== ea) begin n_errors++; $display("FAIL drain_a t=%0t got=%h exp=%h", $time, oa, ea); end
          if (ob !== eb) begin n_errors++; $display("FAIL drain_b t=%0t got=%h exp=%h", $time, ob, eb); end
          if (!oa.active) begin fall = n; break; end
        end
        n_checks += 2;
        if (fall !== FT - p0) begin n_errors++; $display("FAIL drain_fall got=%0d exp=%0d", fall, FT - p0); end
        if (if_b.frame_cnt !== 8'(f0 + 1)) begin
          n_errors++; $display("FAIL drain_fcnt got=%0d exp=%0d", if_b.frame_cnt, f0 + 1);
        end
        for (int n = 0; n < 10; n++) begin
          tick(ea, eb, oa, ob);
          n_checks += 2;
          if (oa !== ea) begin n_errors++; $display("FAIL stopped_a t=%0t got=%h exp=%h", $time, oa, ea); end
          if (ob !== eb) begin n_errors++; $display("FAIL stopped_b t=%0t got=%h exp=%h", $time, ob, eb); end
        end
        run = 1'b1;
      end else begin
        repeat (3 * HT) begin
          tick(ea, eb, oa, ob);
          n_checks += 2;
          if (oa !== ea) begin n_errors++; $display("FAIL drain2_a t=%0t got=%h exp=%h", $time, oa, ea); end
          if (ob !== eb) begin n_errors++; $display("FAIL drain2_b t=%0t got=%h exp=%h", $time, ob, eb); end
        end
        run = 1'b1;
        for (int n = 0; n < 2 * FT; n++) begin
          tick(ea, eb, oa, ob);
          n_checks += 2;
          if (oa !== ea) begin n_errors++; $display("FAIL resume_a t=%0t got=%h exp=%h", $time, oa, ea); end
          if (ob !== eb) begin n_errors++; $display("FAIL resume_b t=%0t got=%h exp=%h", $time, ob, eb); end
          if (!oa.active) gaps++;
        end
        n_checks++;
        if (gaps !== 0) begin n_errors++; $display("FAIL resume_gap got=%0d exp=0", gaps); end
      end
    end
  endtask

  task automatic test_midframe_reset();
    snap_t ea, eb, oa, ob;
    int ta = -1, tf = -1;
    bit found = 1'b0;
    for (int n = 0; n < 2 * FT && !found; n++) begin
      tick(ea, eb, oa, ob);
      n_checks += 2;
      if (oa !== ea) begin n_errors++; $display("FAIL prereset_a t=%0t got=%h exp=%h", $time, oa, ea); end
      if (ob !== eb) begin n_errors++; $display("FAIL prereset_b t=%0t got=%h exp=%h", $time, ob, eb); end
      if (m_on && m_p == HT + 4) found = 1'b1;
    end
    n_checks++;
    if (!found) begin n_errors++; $display("FAIL midline_timeout got=0 exp=1"); end
    #2 rst_n = 1'b0;
    #1;
    n_checks += 2;
    if (obs_a() !== '0) begin n_errors++; $display("FAIL midreset_a got=%h exp=0", obs_a()); end
    if (obs_b() !== '0) begin n_errors++; $display("FAIL midreset_b got=%h exp=0", obs_b()); end
    sb_flush();
    @(negedge clk) rst_n = 1'b1;
    for (int n = 0; n < 2 * FT && tf < 0; n++) begin
      tick(ea, eb, oa, ob);
      n_checks += 2;
      if (oa !== ea) begin n_errors++; $display("FAIL restart_a t=%0t got=%h exp=%h", $time, oa, ea); end
      if (ob !== eb) begin n_errors++; $display("FAIL restart_b t=%0t got=%h exp=%h", $time, ob, eb); end
      if (oa.active && ta < 0) ta = n;
      if (oa.v.fs && tf < 0) tf = n;
    end
    n_checks++;
    if (ta < 0 || tf - ta !== LAT + 1) begin
      n_errors++; $display("FAIL restart_latency got=%0d exp=%0d", tf - ta, LAT + 1);
    end
  endtask

  task automatic test_frame_count();
    snap_t ea, eb, oa, ob;
    int exp_seq[5] = '{1, 2, 3, 0, 1};
    int seq[$];
    int fs_cnt = 0, ls_cnt = 0;
    logic [1:0] prev = 2'd0;
    rst_n = 1'b0;
    sb_flush();
    @(negedge clk) rst_n = 1'b1;
    run = 1'b1;
    for (int n = 0; n < 6 * FT && seq.size() < 5; n++) begin
      tick(ea, eb, oa, ob);
      n_checks += 2;
      if (oa !== ea) begin n_errors++; $display("FAIL frames_a t=%0t got=%h exp=%h", $time, oa, ea); end
      if (ob !== eb) begin n_errors++; $display("FAIL frames_b t=%0t got=%h exp=%h", $time, ob, eb); end
      if (if_a.frame_cnt !== prev) begin
        seq.push_back(int'(if_a.frame_cnt));
        prev = if_a.frame_cnt;
      end
      if (oa.v.fs) fs_cnt++;
      if (oa.v.ls) ls_cnt++;
    end
    n_checks += 3;
    if (seq.size() !== 5) begin n_errors++; $display("FAIL fcnt_changes got=%0d exp=5", seq.size()); end
    if (fs_cnt !== 5) begin n_errors++; $display("FAIL frame_start_cnt got=%0d exp=5", fs_cnt); end
    if (ls_cnt !== 5 * VA) begin n_errors++; $display("FAIL line_start_cnt got=%0d exp=%0d", ls_cnt, 5 * VA); end
    for (int i = 0; i < seq.size() && i < 5; i++) begin
      n_checks++;
      if (seq[i] !== exp_seq[i]) begin
        n_errors++; $display("FAIL fcnt_seq[%0d] got=%0d exp=%0d", i, seq[i], exp_seq[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_polarity();
    test_drain();
    test_midframe_reset();
    test_frame_count();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
